mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 61 ++++++
 tb/tb_mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word-addressed memory with error qualification
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        addr_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [AW-1:0] idx;
  logic [31:0] wd;
  logic is_wr, err, accept, commit;
  logic [31:0] store [DEPTH];
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];
  // next state and status outputs, all derived from the registered state
  always_comb begin
    accept    = state == IDLE && (mem_read_flag || mem_write_flag);
    commit    = state == BUSY && cnt == 4'd0;
    state_nxt = state == IDLE ? (accept ? BUSY : IDLE) :
                state == BUSY ? (commit ? DONE : BUSY) : IDLE;
    mem_busy  = state != IDLE;
    mem_ready = state == DONE;
    addr_err  = mem_ready && err;
  end
  // state, latency counter, request latch and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 32'd0;
      err   <= 1'b0;
      is_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= accept ? 4'(LATENCY - 1) : (state == BUSY && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      if (accept) begin
        idx   <= addr[AW+1:2];
        wd    <= wdata;
        is_wr <= mem_write_flag;
        err   <= (mem_read_flag && mem_write_flag) || addr[1:0] != 2'b00;
      end
      if (commit && !err && !is_wr) rdata <= store[idx];
    end
  end
  // store writes commit only on a clean write leaving BUSY; reset aborts them
  always_ff @(posedge clk) begin
    if (!rst && commit && !err && is_wr) store[idx] <= wd;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks against a word-array model
module tb_mem_responder;
  localparam int DEPTH = 256;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b1, rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic mem_ready, mem_busy, addr_err;
  int checks = 0, failures = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rd = 32'd0;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_read_flag(rd), .mem_write_flag(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .mem_ready(mem_ready), .mem_busy(mem_busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input string name);
    bit e;
    int idx, n;
    e = (r && w) || (a[1:0] != 2'b00);
    idx = int'((a >> 2) & (DEPTH - 1));
    if (!e && w) model_mem[idx] = d;
    if (!e && r) exp_rd = model_mem[idx];
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    checks++;
    if (mem_busy !== 1'b1 || mem_ready !== 1'b0)
      $display("FAIL %s accept: busy=%b ready=%b expected busy=1 ready=0", name, mem_busy, mem_ready);
    if (mem_busy !== 1'b1 || mem_ready !== 1'b0) failures++;
    n = 0;
    while (mem_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != LAT) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, n, LAT);
    end
    checks++;
    if (addr_err !== e) begin
      failures++;
      $display("FAIL %s addr_err: got %b expected %b", name, addr_err, e);
    end
    checks++;
    if (rdata !== exp_rd) begin
      failures++;
      $display("FAIL %s rdata: got %h expected %h", name, rdata, exp_rd);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_ready !== 1'b0 || mem_busy !== 1'b0 || addr_err !== 1'b0) begin
      failures++;
      $display("FAIL %s pulse_end: ready=%b busy=%b err=%b expected 0 0 0", name, mem_ready, mem_busy, addr_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rd = 1'b1; wr = 1'b1; addr = 32'h10; wdata = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rdata !== 32'd0 || mem_ready !== 1'b0 || mem_busy !== 1'b0 || addr_err !== 1'b0) begin
      failures++;
      $display("FAIL reset outputs: rdata=%h ready=%b busy=%b err=%b expected all 0", rdata, mem_ready, mem_busy, addr_err);
    end
    @(negedge clk);
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    exp_rd = 32'd0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) do_req(1'b0, 1'b1, 32'(i * 4), $urandom, "fill");
  endtask

  task automatic test_basic();
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "basic_wr");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, "basic_rd");
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_value: got %h expected deadbeef", rdata);
    end
  endtask

  task automatic test_errors();
    do_req(1'b1, 1'b0, 32'h13, 32'h0, "misaligned_rd");
    do_req(1'b0, 1'b1, 32'h11, 32'h77, "misaligned_wr");
    do_req(1'b1, 1'b1, 32'h10, 32'h1, "both_flags");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, "after_illegal");
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL illegal_no_write: got %h expected deadbeef", rdata);
    end
  endtask

  task automatic test_ignore_busy();
    int pulses;
    do_req(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, "ib_first");
    model_mem[8] = 32'h5A5A5A5A;
    @(negedge clk);
    wr = 1'b1; addr = 32'h20; wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    @(negedge clk);
    wdata = 32'hFFFFFFFF;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) pulses++;
      if (i == 0) wr = 1'b0;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL ignore_busy pulses: got %0d expected 1", pulses);
    end
    do_req(1'b1, 1'b0, 32'h20, 32'h0, "ib_read");
    checks++;
    if (rdata !== 32'h5A5A5A5A) begin
      failures++;
      $display("FAIL ignore_busy value: got %h expected 5a5a5a5a", rdata);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    do_req(1'b0, 1'b1, 32'h30, 32'h11111111, "abort_first");
    @(negedge clk);
    wr = 1'b1; addr = 32'h30; wdata = 32'h22222222;
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_busy !== 1'b0 || mem_ready !== 1'b0 || rdata !== 32'd0) begin
      failures++;
      $display("FAIL abort state: busy=%b ready=%b rdata=%h expected 0 0 0", mem_busy, mem_ready, rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 32'd0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL abort pulses: got %0d expected 0", pulses);
    end
    do_req(1'b1, 1'b0, 32'h30, 32'h0, "abort_read");
    checks++;
    if (rdata !== 32'h11111111) begin
      failures++;
      $display("FAIL abort value: got %h expected 11111111", rdata);
    end
  endtask

  task automatic test_wrap();
    do_req(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, "wrap_wr");
    do_req(1'b1, 1'b0, 32'h0, 32'h0, "wrap_rd");
    checks++;
    if (rdata !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL wrap value: got %h expected cafef00d", rdata);
    end
  endtask

  task automatic test_random();
    int op;
    logic [31:0] a;
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_req(op == 0 || (op >= 1 && op <= 4), op == 0 || op >= 5, a, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_errors();
    test_ignore_busy();
    test_reset_abort();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
